// File: rtl/inst_queue.sv
// Circular instruction buffer between fetch and decode/issue.
// Fetch pushes one word per cycle and decode pops one per cycle, each side
// using a valid/ready handshake. Reads are first-word fall-through: the head
// word is presented combinationally. A flush empties the queue on a
// branch mispredict.
module inst_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage holds only data and is never reset; occupancy comes from the pointers.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Each pointer has one extra wrap bit, so full and empty can be told apart
  // when the index bits are equal.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Increment modulo 2**(ADDR_WIDTH+1). Carrying out of the index bits
  // toggles the wrap bit.
  function automatic logic [ADDR_WIDTH:0] ptr_inc(input logic [ADDR_WIDTH:0] p);
    return p + 1'b1;
  endfunction

  assign wr_idx = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_idx = rd_ptr[ADDR_WIDTH-1:0];

  // Status signals depend only on the registered pointers.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_idx == rd_idx) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    in_ready  = !full;
    out_valid = !empty;
    count     = wr_ptr - rd_ptr;
    push      = in_valid && !full;
    pop       = out_ready && !empty;
  end

  // The head word falls through with no bypass. Its value is meaningless
  // while the queue is empty.
  assign out_data = mem[rd_idx];

  // Write the array on an accepted push. A flush in the same cycle drops the word.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_idx] <= in_data;
    end
  end

  // Pointer update. Reset is asynchronous. A flush takes priority over any
  // push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed, self-checking bench for inst_queue: a table of single-cycle
// vectors plus hand-written multi-cycle sequences.
module tb_inst_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [4:0]  count;

  int checks;
  int errors;

  inst_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic [4:0]  cnt;
    logic        ir;
    logic        ov;
    logic [31:0] od;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    drive(fl, iv, d, ordy);
    tick();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();

    //               fl iv  data    ordy cnt ir ov  od
    vt[0] = '{1'b0, 1'b1, 32'h11, 1'b0, 5'd1, 1'b1, 1'b1, 32'h11};
    vt[1] = '{1'b0, 1'b1, 32'h22, 1'b0, 5'd2, 1'b1, 1'b1, 32'h11};
    vt[2] = '{1'b0, 1'b1, 32'h33, 1'b1, 5'd2, 1'b1, 1'b1, 32'h22};
    vt[3] = '{1'b0, 1'b0, 32'h00, 1'b1, 5'd1, 1'b1, 1'b1, 32'h33};
    vt[4] = '{1'b0, 1'b1, 32'h44, 1'b1, 5'd1, 1'b1, 1'b1, 32'h44};
    vt[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 5'd0, 1'b1, 1'b0, 32'h00};
    vt[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 5'd0, 1'b1, 1'b0, 32'h00};
    vt[7] = '{1'b0, 1'b1, 32'h55, 1'b1, 5'd1, 1'b1, 1'b1, 32'h55};
    vt[8] = '{1'b1, 1'b1, 32'h66, 1'b1, 5'd0, 1'b1, 1'b0, 32'h00};
    vt[9] = '{1'b0, 1'b1, 32'h77, 1'b0, 5'd1, 1'b1, 1'b1, 32'h77};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].ir));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].ov));
      if (vt[i].ov) chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vt[i].od));
    end

    // Reset mid-stream
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h900 + i, 0);
    chk("mid_pre_count", 64'(count), 64'd3);
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    cyc(0, 1, 32'hA, 0);
    chk("mid_push_out_valid", 64'(out_valid), 64'd1);
    chk("mid_push_out_data", 64'(out_data), 64'hA);
    chk("mid_push_count", 64'(count), 64'd1);

    // Fill, overflow attempt, full with concurrent pop, drain
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 32'h100 + i, 0);
      chk($sformatf("fill%0d_count", i), 64'(count), 64'(i + 1));
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cyc(0, 1, 32'hDEAD, 0);
    chk("overflow_count", 64'(count), 64'd16);
    chk("overflow_head", 64'(out_data), 64'h100);
    cyc(0, 1, 32'h55, 1);
    chk("fullpop_count", 64'(count), 64'd15);
    chk("fullpop_in_ready", 64'(in_ready), 64'd1);
    chk("fullpop_head", 64'(out_data), 64'h101);
    cyc(0, 1, 32'h55, 0);
    chk("refill_count", 64'(count), 64'd16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1);
      chk($sformatf("drain%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d_data", i), 64'(out_data), (i < 15) ? 64'(32'h101 + i) : 64'h55);
      tick();
    end
    chk("drained_out_valid", 64'(out_valid), 64'd0);
    chk("drained_count", 64'(count), 64'd0);

    // Wrap-around across index 15 -> 0
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 32'h700 + i, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    chk("wrap_empty", 64'(out_valid), 64'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 32'h200 + i, 0);
      chk($sformatf("wrap_push%0d_count", i), 64'(count), 64'(i + 1));
    end
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1);
      chk($sformatf("wrap_pop%0d_data", i), 64'(out_data), 64'(32'h200 + i));
      tick();
      chk($sformatf("wrap_pop%0d_count", i), 64'(count), 64'(11 - i));
    end

    // Simultaneous push/pop at a steady count of 5
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h300 + i, 0);
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 32'h305 + i, 1);
      chk($sformatf("pp%0d_data", i), 64'(out_data), 64'(32'h300 + i));
      tick();
      chk($sformatf("pp%0d_count", i), 64'(count), 64'd5);
    end

    // Flush priority over concurrent push and pop
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 32'h400 + i, 0);
    chk("fl_pre_count", 64'(count), 64'd7);
    cyc(1, 1, 32'h77, 1);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    cyc(0, 1, 32'h88, 0);
    chk("fl_push_count", 64'(count), 64'd1);
    chk("fl_push_data", 64'(out_data), 64'h88);
    cyc(0, 0, 0, 1);
    chk("fl_after_pop_valid", 64'(out_valid), 64'd0);
    chk("fl_after_pop_count", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular instruction buffer between fetch (writer side) and decode/issue (reader side) of the CPU.
- Fetch pushes one instruction word per cycle; decode pops one per cycle through valid/ready handshakes.
- Write and read pointers advance independently and wrap modulo DEPTH.
- A synchronous flush discards all entries on branch mispredict.

Parameters:
- DATA_WIDTH, 32, width of each stored instruction word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH = 16 entries.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  writer presents in_data.
- in_data  input  DATA_WIDTH  instruction word to store.
- in_ready  output  1  queue can accept a word (not full).
- out_valid  output  1  head entry is valid (not empty).
- out_data  output  DATA_WIDTH  head entry contents.
- out_ready  input  1  reader consumes the head entry this cycle.
- count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array; contents are not reset.
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits.
  - Low ADDR_WIDTH bits index the array; the MSB is a wrap bit.
  - Empty when wr_ptr == rd_ptr.
  - Full when the low bits are equal and the MSBs differ.
- Status outputs:
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
  - in_ready = !full; out_valid = !empty; both derived combinationally from registered pointers.
- Push: in_valid && in_ready at a rising edge writes mem[wr_ptr low bits] <= in_data and increments wr_ptr.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr.
- out_data = mem[rd_ptr low bits] combinationally (first-word fall-through). Value is don't-care while out_valid=0.
- Latency: a word pushed into an empty queue appears on out_data with out_valid=1 on the cycle after the push edge. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - Allowed at any occupancy except full and empty.
  - Full: in_ready=0, so no push even if a pop occurs that cycle; in_ready rises the next cycle.
  - Empty: out_valid=0, so no pop; the push still occurs.
- Wrap-around: each pointer increments past index DEPTH-1 to index 0 and toggles its MSB. Ordering is strictly FIFO across the wrap.
- Push/pop attempts while full/empty are ignored: no pointer change, no memory write, and the data is not lost silently. The writer must hold in_valid/in_data until in_ready is 1.
- Flush:
  - On a rising edge with flush=1, wr_ptr <= 0 and rd_ptr <= 0.
  - Flush dominates any push or pop in the same cycle; the pushed word is discarded.
  - Next cycle: count=0, out_valid=0, in_ready=1.
- Reset (rst=1, asynchronous, any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0 immediately, so count=0, out_valid=0, in_ready=1.
  - Memory array is left untouched.
  - Normal operation resumes on the first rising edge after rst deasserts.

Test Plan:
- Reset mid-stream: push 3 words, assert rst between edges -> count=0, out_valid=0, in_ready=1 before the next edge; push 0xA after release -> out_data=0xA one cycle later.
- Fill and drain: push 0x100..0x10F with out_ready=0 -> after the 16th push, count=16 and in_ready=0; a 17th push of 0xDEAD is ignored; popping 16 times returns 0x100..0x10F in order, then out_valid=0.
- Wrap-around: push 10, pop 10, then push 12 words 0x200..0x20B -> pointers cross index 15->0; popped order is 0x200..0x20B and count tracks 12 down to 0.
- Simultaneous push/pop: hold count=5, push+pop every cycle for 40 cycles with incrementing data -> count stays 5 and output sequence equals input delayed by 5 entries.
- Full with concurrent pop: at count=16 assert in_valid(0x55) and out_ready -> pop occurs, push does not, count=15; next cycle in_ready=1 and 0x55 is accepted.
- Flush priority: at count=7 assert flush with in_valid(0x77) and out_ready -> next cycle count=0, out_valid=0; a subsequent push of 0x88 is the only word read out.
